// File: rtl/fir_mac_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : fir_mac_seq_if
// Sample handshake, coefficient write port and result bundle for fir_mac_seq.
// Rev    : 1.0
// ----------------------------------------------------------------------------
interface fir_mac_seq_if #(
  parameter int DW = 16,
  parameter int CW = 16,
  parameter int OW = 32,
  parameter int AW = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] f_in;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 out_valid;
  logic signed [OW-1:0] f_out;
  logic                 busy;

  modport master (
    output in_valid, f_in, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, f_out, busy
  );

  modport slave (
    input  in_valid, f_in, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, f_out, busy
  );
endinterface
`default_nettype wire

// File: rtl/fir_mac_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : fir_mac_seq
// Time-multiplexed FIR on one MAC; runtime coefficients, rounded/saturated out.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module fir_mac_seq #(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int TAPS  = 32,
  parameter int OW    = 32,
  parameter int SHIFT = 0
) (
  input  wire logic    clk,
  input  wire logic    rst,
  fir_mac_seq_if.slave bus
);
  localparam int AW   = $clog2(TAPS);
  localparam int PW   = DW + CW;
  localparam int ACCW = DW + CW + AW;
  localparam int WW   = ((ACCW + 1 > OW) ? ACCW + 1 : OW) + 1;
  localparam logic [AW-1:0]        c_last     = AW'(TAPS - 1);
  localparam logic [AW-1:0]        c_taps_mod = AW'(TAPS);
  localparam logic signed [WW-1:0] c_out_max  = (WW'(1) <<< (OW - 1)) - WW'(1);
  localparam logic signed [WW-1:0] c_out_min  = -(WW'(1) <<< (OW - 1));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          k_q, k_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [DW-1:0]   dline_q [TAPS];
  logic signed [DW-1:0]   dline_d [TAPS];
  logic signed [CW-1:0]   coef_q  [TAPS];
  logic signed [CW-1:0]   coef_d  [TAPS];
  logic signed [OW-1:0]   f_out_q, f_out_d;
  logic                   out_valid_q, out_valid_d;
  logic                   in_ready_q, in_ready_d;
  logic                   busy_q, busy_d;

  logic [AW-1:0]          w_rd_idx;
  logic signed [PW-1:0]   w_x_ext, w_c_ext, w_prod;
  logic signed [ACCW:0]   w_acc_ext, w_rounded;
  logic signed [WW-1:0]   w_wide;
  logic signed [OW-1:0]   w_sat;

  // Modular subtraction; for power-of-two TAPS the wrap term is zero.
  assign w_rd_idx  = wr_ptr_q - k_q + ((wr_ptr_q >= k_q) ? '0 : c_taps_mod);
  assign w_x_ext   = {{CW{dline_q[w_rd_idx][DW-1]}}, dline_q[w_rd_idx]};
  assign w_c_ext   = {{DW{coef_q[k_q][CW-1]}}, coef_q[k_q]};
  assign w_prod    = w_x_ext * w_c_ext;
  assign w_acc_ext = {acc_q[ACCW-1], acc_q};

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [ACCW:0] c_half = (ACCW + 1)'(1) <<< (SHIFT - 1);
      assign w_rounded = (w_acc_ext + c_half) >>> SHIFT;
    end else begin : g_no_round
      assign w_rounded = w_acc_ext;
    end
  endgenerate

  assign w_wide = {{(WW - ACCW - 1){w_rounded[ACCW]}}, w_rounded};
  assign w_sat  = (w_wide > c_out_max) ? c_out_max[OW-1:0] :
                  (w_wide < c_out_min) ? c_out_min[OW-1:0] : w_wide[OW-1:0];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    k_d         = k_q;
    acc_d       = acc_q;
    dline_d     = dline_q;
    coef_d      = coef_q;
    f_out_d     = f_out_q;
    out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.coef_we) coef_d[bus.coef_addr] = bus.coef_data;
        if (bus.in_valid) begin
          dline_d[wr_ptr_q] = bus.f_in;
          acc_d             = '0;
          k_d               = '0;
          state_d           = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + {{(ACCW - PW){w_prod[PW-1]}}, w_prod};
        if (k_q == c_last) state_d = S_OUT;
        else               k_d     = k_q + AW'(1);
      end
      S_OUT: begin
        f_out_d     = w_sat;
        out_valid_d = 1'b1;
        wr_ptr_d    = (wr_ptr_q == c_last) ? '0 : wr_ptr_q + AW'(1);
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d == S_MAC);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      f_out_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        dline_q[i] <= '0;
        coef_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      f_out_q     <= f_out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      dline_q     <= dline_d;
      coef_q      <= coef_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.f_out     = f_out_q;
  assign bus.busy      = busy_q;
endmodule
`default_nettype wire

// File: doc/fir_mac_seq.md
Name: fir_mac_seq

Overview:
Parametrised, time-multiplexed FIR low-pass filter built on a single multiplier-accumulator. It takes one signed sample per valid/ready handshake and computes the TAPS-tap convolution over TAPS clock cycles. It then emits one rounded, saturated result with an out_valid strobe. Coefficients are runtime-programmable through a write port, so one instance covers any low-pass (or other) response up to TAPS taps.

Parameters:
DW, 16, input sample width (signed)
CW, 16, coefficient width (signed)
TAPS, 32, number of taps; must be >= 2
OW, 32, output width (signed)
SHIFT, 0, arithmetic right shift applied to the accumulator before output (round-half-up when > 0)
AW, $clog2(TAPS), coefficient address width (derived; not overridden)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  f_in holds a sample
in_ready  out  1  block can accept a sample (high only in IDLE)
f_in  in  DW  signed input sample
coef_we  in  1  coefficient write strobe
coef_addr  in  AW  tap index 0..TAPS-1; c[0] multiplies the newest sample
coef_data  in  CW  signed coefficient value
out_valid  out  1  one-cycle strobe, f_out valid
f_out  out  OW  signed filtered output, held until the next out_valid
busy  out  1  high in MAC state

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; delay line, all coefficients, accumulator, tap counter, write pointer cleared to 0; f_out=0, out_valid=0, busy=0. in_ready=1 while in IDLE, including during reset.
- Delay line: circular buffer of TAPS DW-bit samples. The write pointer wraps from TAPS-1 to 0. The read index for tap k is (wr_ptr_of_newest - k) mod TAPS.
- States:
  - IDLE: in_ready=1. On in_valid=1 at an edge, store f_in at wr_ptr, clear acc, set k=0, go to MAC.
  - MAC: each edge, acc += x[n-k]*c[k], then k++. After the edge with k=TAPS-1, go to OUT.
  - OUT: one edge. Register f_out=sat(round(acc)), pulse out_valid=1, advance wr_ptr, return to IDLE.
- Timing: a sample accepted at edge 0 is accumulated at edges 1..TAPS. f_out/out_valid are registered at edge TAPS+1. out_valid is high for exactly one cycle, and in_ready is high in that same cycle.
- Throughput: with in_valid held high, one sample is accepted every TAPS+2 cycles. in_valid while in_ready=0 is ignored; the source must hold the sample until in_ready.
- Arithmetic: products are CW+DW bits. The accumulator is DW+CW+AW bits signed and cannot overflow.
  - SHIFT>0: add 2^(SHIFT-1), then arithmetic shift right by SHIFT.
  - Result > 2^(OW-1)-1 → saturates to max; result < -2^(OW-1) → saturates to min. No wrap.
- Coefficient writes: accepted only in IDLE; coef_we in MAC/OUT is dropped silently. coef_we and in_valid in the same IDLE cycle are both accepted, and the new coefficient applies to that sample. Writing two taps requires two IDLE cycles.
- Reset mid-operation: the in-flight sample is discarded and no out_valid is produced for it. History is cleared, so the next response starts from zero state. Coefficients must be reloaded.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with in_valid toggling → f_out=0, out_valid=0, busy=0, in_ready=1. After release, an input of 100 with all coefficients 0 → f_out=0.
2. Impulse (TAPS=8, SHIFT=0, c[k]=k+1): inputs 1,0,0,... → successive out_valid values 1,2,3,4,5,6,7,8,0. Each out_valid arrives exactly 9 cycles after its acceptance edge.
3. Saturation (TAPS=8, OW=16, SHIFT=0, all c=32767): constant input 32767 → f_out=32767. Constant input -32768 → f_out=-32768.
4. Rounding (SHIFT=1, c[0]=1, rest 0): inputs 3, -3, 2 → f_out 2, -1, 1.
5. Handshake/backpressure: in_valid held high for 5 samples → acceptances spaced exactly TAPS+2 cycles apart, exactly 5 out_valid pulses, no sample skipped or duplicated.
6. Coefficient timing: write c[0]=5 during MAC → dropped, output unchanged. Write c[0]=5 in the same IDLE cycle as input 2 → f_out=10. Assert rst mid-MAC → no out_valid for that sample, and a subsequent impulse reproduces the clean response.
